// File: rtl/clkdiv_reset_gen.sv
// Reset sequencer with debounced manual request and per-channel clock dividers.
// Dividers are held cleared for the entire stretched reset window.
module clkdiv_reset_gen #(
    parameter int NUM_CH          = 2,
    parameter int CNT_W           = 16,
    parameter int HOLD_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    manual_rst,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*CNT_W-1:0] div_val,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       square,
    output logic                    sys_rst,
    output logic                    rst_done
);

    typedef enum logic {HOLD = 1'b0, RUN = 1'b1} state_t;

    localparam logic [3:0] DB_MAX    = 4'(DEBOUNCE_CYCLES);
    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state, state_n;
    logic [7:0] hold_cnt, hold_n;
    logic       sync1, sync2;
    logic [3:0] db_cnt;
    logic       accept;
    logic       clr;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= manual_rst;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            db_cnt <= 4'd0;
        end else if (!sync2) begin
            db_cnt <= 4'd0;
        end else if (db_cnt != DB_MAX) begin
            db_cnt <= db_cnt + 4'd1;
        end
    end

    // Fires only on the step into saturation, so a held button requests once.
    assign accept = sync2 && (db_cnt == DB_MAX - 4'd1);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= HOLD;
            hold_cnt <= 8'd0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
        end
    end

    always_comb begin
        state_n = state;
        hold_n  = hold_cnt;
        unique case (state)
            HOLD: begin
                if (accept) begin
                    hold_n = 8'd0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_n = RUN;
                    hold_n  = 8'd0;
                end else begin
                    hold_n = hold_cnt + 8'd1;
                end
            end
            RUN: begin
                if (accept) begin
                    state_n = HOLD;
                    hold_n  = 8'd0;
                end
            end
        endcase
    end

    always_comb begin
        sys_rst  = 1'b1;
        rst_done = 1'b0;
        unique case (state)
            HOLD: begin
                sys_rst  = 1'b1;
                rst_done = 1'b0;
            end
            RUN: begin
                sys_rst  = 1'b0;
                rst_done = 1'b1;
            end
        endcase
    end

    // Channels clear on the same edge sys_rst rises.
    assign clr = (state_n == HOLD);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] count;
        logic [CNT_W-1:0] dv;
        logic             tk;
        logic             sq;

        assign dv        = div_val[g*CNT_W +: CNT_W];
        assign tick[g]   = tk;
        assign square[g] = sq;

        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                count <= '0;
                tk    <= 1'b0;
                sq    <= 1'b0;
            end else if (clr) begin
                count <= '0;
                tk    <= 1'b0;
                sq    <= 1'b0;
            end else if (!enable[g]) begin
                tk <= 1'b0;
            end else if (count >= dv) begin
                count <= '0;
                tk    <= 1'b1;
                sq    <= ~sq;
            end else begin
                count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
                tk    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_reset_gen.sv
// Directed bench for clkdiv_reset_gen: power-on, dividers, retarget,
// debounce and asynchronous abort.
module tb_clkdiv_reset_gen;

    logic        clk;
    logic        n_rst;
    logic        manual_rst;
    logic [1:0]  enable;
    logic [31:0] div_val;
    logic [1:0]  tick;
    logic [1:0]  square;
    logic        sys_rst;
    logic        rst_done;

    int tests;
    int fails;
    int found;

    clkdiv_reset_gen dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .manual_rst (manual_rst),
        .enable     (enable),
        .div_val    (div_val),
        .tick       (tick),
        .square     (square),
        .sys_rst    (sys_rst),
        .rst_done   (rst_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_por();
        for (int e = 1; e <= 4; e++) begin
            @(negedge clk);
            chk($sformatf("hold_sys_rst_e%0d", e), int'(sys_rst), int'(e < 4));
            chk($sformatf("hold_rst_done_e%0d", e), int'(rst_done), int'(e == 4));
        end
    endtask

    initial begin
        tests      = 0;
        fails      = 0;
        found      = 0;
        n_rst      = 1'b0;
        manual_rst = 1'b0;
        enable     = 2'b00;
        div_val    = {16'd0, 16'd5};

        repeat (2) @(negedge clk);
        chk("rst_sys_rst", int'(sys_rst), 1);
        chk("rst_rst_done", int'(rst_done), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_square", int'(square), 0);

        n_rst = 1'b1;
        chk_por();

        enable = 2'b11;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            chk($sformatf("div_tick0_n%0d", n), int'(tick[0]), int'(n % 6 == 0));
            chk($sformatf("div_sq0_n%0d", n), int'(square[0]), (n / 6) % 2);
            chk($sformatf("div_tick1_n%0d", n), int'(tick[1]), 1);
            chk($sformatf("div_sq1_n%0d", n), int'(square[1]), n % 2);
        end

        div_val[15:0] = 16'd9;
        repeat (7) @(negedge clk);
        chk("ret_count_at7", int'(dut.g_ch[0].count), 7);
        enable[0] = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            chk($sformatf("dis_count_k%0d", k), int'(dut.g_ch[0].count), 7);
            chk($sformatf("dis_tick0_k%0d", k), int'(tick[0]), 0);
            chk($sformatf("dis_sq0_k%0d", k), int'(square[0]), 0);
        end
        enable[0]     = 1'b1;
        div_val[15:0] = 16'd3;
        for (int m = 1; m <= 9; m++) begin
            @(negedge clk);
            chk($sformatf("ret_tick0_m%0d", m), int'(tick[0]), int'(m % 4 == 1));
        end
        chk("ret_sq0", int'(square[0]), 1);

        manual_rst = 1'b1;
        repeat (2) @(negedge clk);
        manual_rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("glitch_sys_rst_k%0d", k), int'(sys_rst), 0);
        end

        div_val[15:0] = 16'd9;
        manual_rst    = 1'b1;
        for (int e = 1; e <= 14; e++) begin
            @(negedge clk);
            chk($sformatf("db_sys_rst_e%0d", e), int'(sys_rst),
                int'(e >= 5 && e <= 8));
            chk($sformatf("db_rst_done_e%0d", e), int'(rst_done),
                int'(!(e >= 5 && e <= 8)));
            if (e == 5) begin
                chk("db_tick_clr", int'(tick), 0);
                chk("db_square_clr", int'(square), 0);
                chk("db_count_clr", int'(dut.g_ch[0].count), 0);
            end
            if (e == 10) manual_rst = 1'b0;
        end

        for (int w = 0; w < 30; w++) begin
            if (dut.g_ch[0].count == 16'd4) begin
                found = 1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_reach_cnt4", found, 1);
        chk("abort_pre_run", int'(rst_done), 1);

        #2 n_rst = 1'b0;
        #1;
        chk("abort_sys_rst", int'(sys_rst), 1);
        chk("abort_rst_done", int'(rst_done), 0);
        chk("abort_tick", int'(tick), 0);
        chk("abort_square", int'(square), 0);
        chk("abort_count", int'(dut.g_ch[0].count), 0);
        @(negedge clk);
        chk("abort_held_sys_rst", int'(sys_rst), 1);
        n_rst = 1'b1;
        chk_por();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
